// File: rtl/imem_fetch.sv
// imem_fetch: Hack CPU instruction fetch responder.
// Takes PC-side address requests and issues reads to a synchronous ROM.
// Returned words go into a small in-order FIFO, which feeds decode over valid/ready.
// flush drops the in-flight read and every buffered entry.
// Optional feature: define FETCH_BOUNDS_CHECK_EN to turn addresses >= ROM_DEPTH
// into fault entries (instr=0, fault=1) without strobing the ROM.
module imem_fetch #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 16,
    parameter int ROM_DEPTH  = 32768,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    input  logic              flush,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              fault
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] addr;
        logic              fault;
    } entry_t;

    logic              pending;
    logic [ADDR_W-1:0] pend_addr;
    logic              pend_fault;

    entry_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    entry_t            head;

    logic              pop, accept, wr_en, req_oob;
    logic [CNT_W:0]    used;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef FETCH_BOUNDS_CHECK_EN
    // Out-of-range fetches are accepted but never reach the ROM.
    assign req_oob = ({1'b0, req_addr} >= (ADDR_W + 1)'(ROM_DEPTH));
`else
    assign req_oob = 1'b0;
`endif

    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready;

    // Credits: buffered + in-flight, minus a same-cycle pop, must leave a free slot.
    // pop implies count >= 1, so the subtraction cannot underflow.
    assign used      = {1'b0, count} + (CNT_W + 1)'(pending) - (CNT_W + 1)'(pop);
    assign req_ready = reset_n && !flush && (used < (CNT_W + 1)'(FIFO_DEPTH));
    assign accept    = req_valid && req_ready;

    assign rom_en   = accept && !req_oob;
    assign rom_addr = req_addr;

    // The ROM word for last cycle's accept lands in the FIFO unless flushed.
    assign wr_en = pending && !flush;

    assign head       = mem[rd_ptr];
    assign instr      = head.instr;
    assign instr_addr = head.addr;
    assign fault      = head.fault;

    // Track the single read in flight and its address tag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending    <= 1'b0;
            pend_addr  <= '0;
            pend_fault <= 1'b0;
        end else if (flush) begin
            pending    <= 1'b0;
        end else begin
            pending <= accept;
            if (accept) begin
                pend_addr  <= req_addr;
                pend_fault <= req_oob;
            end
        end
    end

    // In-order output FIFO; flush empties it without touching storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr].instr <= pend_fault ? '0 : rom_data;
                mem[wr_ptr].addr  <= pend_addr;
                mem[wr_ptr].fault <= pend_fault;
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(wr_en) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_imem_fetch.sv
// tb_imem_fetch: scoreboard bench for imem_fetch.
// Accepted requests push expected entries; a negedge monitor pops and compares deliveries.
module tb_imem_fetch;

    localparam int AW = 15;
    localparam int DW = 16;
    localparam int RD = 16;
    localparam int FD = 2;

    logic          clk = 1'b0;
    logic          reset_n, req_valid, flush, instr_ready;
    logic [AW-1:0] req_addr, rom_addr, instr_addr;
    logic [DW-1:0] rom_data, instr;
    logic          req_ready, rom_en, instr_valid, fault;

    always #5 clk = ~clk;

    imem_fetch #(.ADDR_W(AW), .DATA_W(DW), .ROM_DEPTH(RD), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .flush(flush), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_data(rom_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_addr(instr_addr), .fault(fault)
    );

    // Synchronous ROM: word = addr + 0x1000; garbage when not strobed.
    always @(posedge clk) rom_data <= rom_en ? (DW'(rom_addr) + 16'h1000) : 16'hDEAD;

    typedef struct {
        logic [DW-1:0] instr;
        logic [AW-1:0] addr;
        logic          fault;
        int            due;
        bit            exact;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    bit   tight = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic exp_t model(input logic [AW-1:0] a);
        exp_t e;
        e.addr  = a;
        e.due   = cyc + 2;
        e.exact = tight;
        e.instr = DW'(a) + 16'h1000;
        e.fault = 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
        if (int'(a) >= RD) begin
            e.instr = '0;
            e.fault = 1'b1;
        end
`endif
        return e;
    endfunction

    // Monitor: compare each delivery, then record this cycle's flush/accept.
    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
        end else begin
            if (instr_valid && instr_ready && !flush) begin
                if (q.size() == 0) begin
                    check("spurious_delivery", 32'(instr_addr), 32'hFFFF_FFFF);
                end else begin
                    mon_e = q.pop_front();
                    check("instr", 32'(instr), 32'(mon_e.instr));
                    check("instr_addr", 32'(instr_addr), 32'(mon_e.addr));
                    check("fault", 32'(fault), 32'(mon_e.fault));
                    if (mon_e.exact) check("latency", 32'(cyc), 32'(mon_e.due));
                end
            end
            if (flush) q.delete();
            else if (req_valid && req_ready) q.push_back(model(req_addr));
        end
    end

    task automatic issue(input logic [AW-1:0] a);
        int k;
        req_valid = 1'b1;
        req_addr  = a;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        if (k == 50) check("issue_timeout", 32'(a), 32'hFFFF_FFFF);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 40 && q.size() != 0; k++) @(posedge clk);
        #1;
        check(name, 32'(q.size()), 0);
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0; instr_ready = 1'b0;
        #3;
        check("rst_instr_valid", 32'(instr_valid), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rom_en", 32'(rom_en), 0);
        check("rst_instr", 32'(instr), 0);
        check("rst_instr_addr", 32'(instr_addr), 0);
        check("rst_fault", 32'(fault), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Stream 0..3 at full rate with exact latency.
        instr_ready = 1'b1;
        tight = 1'b1;
        for (int a = 0; a < 4; a++) begin
            req_valid = 1'b1;
            req_addr  = AW'(a);
            @(negedge clk);
            check("stream_ready", 32'(req_ready), 1);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        tight = 1'b0;
        drain("stream_drain");

        // Backpressure: two credits, then stall until a pop.
        instr_ready = 1'b0;
        issue(AW'(5));
        issue(AW'(6));
        req_valid = 1'b1;
        req_addr  = AW'(7);
        repeat (3) begin
            @(negedge clk);
            check("bp_ready_low", 32'(req_ready), 0);
        end
        @(posedge clk); #1;
        instr_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_on_pop", 32'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        drain("bp_drain");

        // Flush with a read in flight; a request offered during flush must be refused.
        issue(AW'(10));
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = AW'(99);
        @(negedge clk);
        check("flush_req_ready", 32'(req_ready), 0);
        check("flush_rom_en", 32'(rom_en), 0);
        @(posedge clk); #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        issue(AW'(20));
        drain("flush_drain");

        // Asynchronous reset with two buffered entries.
        instr_ready = 1'b0;
        issue(AW'(30));
        issue(AW'(31));
        @(posedge clk); #1;
        check("prerst_valid", 32'(instr_valid), 1);
        check("prerst_head", 32'(instr_addr), 30);
        #2 reset_n = 1'b0;
        #1;
        check("arst_instr_valid", 32'(instr_valid), 0);
        check("arst_req_ready", 32'(req_ready), 0);
        check("arst_instr_addr", 32'(instr_addr), 0);
        #3 reset_n = 1'b1;
        instr_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("no_stale", 32'(instr_valid), 0);
        end
        @(posedge clk); #1;
        issue(AW'(40));
        drain("post_rst_drain");

        // Bounds: 15 is in range, 16 is out of range when checking is compiled in.
        req_valid = 1'b1;
        req_addr  = AW'(15);
        @(negedge clk);
        check("rom_en_15", 32'(rom_en), 1);
        @(posedge clk); #1;
        req_addr = AW'(16);
        @(negedge clk);
        check("ready_16", 32'(req_ready), 1);
`ifdef FETCH_BOUNDS_CHECK_EN
        check("rom_en_16", 32'(rom_en), 0);
`else
        check("rom_en_16", 32'(rom_en), 1);
`endif
        @(posedge clk); #1;
        req_valid = 1'b0;
        drain("bounds_drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
